// File: rtl/cclut_fine_position_if.sv
// Bus bundle for cclut_fine_position: both CLCT candidate inputs, counter clear, and the
// fine-position results. master = upstream driver/consumer, slave = the fine-position stage.
interface cclut_fine_position_if #(
    parameter int MXHSB   = 8,
    parameter int MXPIDB  = 4,
    parameter int MXOFFSB = 4,
    parameter int MXBNDB  = 5,
    parameter int MXCNTB  = 16
);
    logic               vld0,  vld1;
    logic [MXHSB-1:0]   hs0,   hs1;
    logic [MXPIDB-1:0]  pid0,  pid1;
    logic [MXOFFSB-1:0] offs0, offs1;
    logic [MXBNDB-1:0]  bend0, bend1;
    logic               cnt_clr;

    logic               vld_out0,   vld_out1;
    logic [MXHSB-1:0]   khs_out0,   khs_out1;
    logic               qs_out0,    qs_out1;
    logic               es_out0,    es_out1;
    logic [3:0]         slope_out0, slope_out1;
    logic               lr_out0,    lr_out1;
    logic [MXPIDB-1:0]  pid_out0,   pid_out1;
    logic               clamp0,     clamp1;
    logic [MXCNTB-1:0]  clamp_cnt0, clamp_cnt1;

    modport master (
        output vld0, vld1, hs0, hs1, pid0, pid1, offs0, offs1, bend0, bend1, cnt_clr,
        input  vld_out0, vld_out1, khs_out0, khs_out1, qs_out0, qs_out1, es_out0, es_out1,
               slope_out0, slope_out1, lr_out0, lr_out1, pid_out0, pid_out1,
               clamp0, clamp1, clamp_cnt0, clamp_cnt1
    );

    modport slave (
        input  vld0, vld1, hs0, hs1, pid0, pid1, offs0, offs1, bend0, bend1, cnt_clr,
        output vld_out0, vld_out1, khs_out0, khs_out1, qs_out0, qs_out1, es_out0, es_out1,
               slope_out0, slope_out1, lr_out0, lr_out1, pid_out0, pid_out1,
               clamp0, clamp1, clamp_cnt0, clamp_cnt1
    );
endinterface

// File: rtl/cclut_fine_position.sv
// CCLUT fine position: offset code -> clamped eighth-strip key position, 2-clock pipeline per CLCT.
// Optional saturating clamp counters are built when CCLUT_CLAMP_CNT_EN is defined.
module cclut_fp_lane #(
    parameter int MXHSB   = 8,
    parameter int MXHS    = 224,
    parameter int MXPIDB  = 4,
    parameter int MXOFFSB = 4,
    parameter int MXBNDB  = 5,
    parameter int MXCNTB  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vld,
    input  logic [MXHSB-1:0]   hs,
    input  logic [MXPIDB-1:0]  pid,
    input  logic [MXOFFSB-1:0] offs,
    input  logic [MXBNDB-1:0]  bend,
    input  logic               cnt_clr,
    output logic               vld_out,
    output logic [MXHSB-1:0]   khs_out,
    output logic               qs_out,
    output logic               es_out,
    output logic [3:0]         slope_out,
    output logic               lr_out,
    output logic [MXPIDB-1:0]  pid_out,
    output logic               clamp_out,
    output logic [MXCNTB-1:0]  clamp_cnt
);
    // vld_pipe[0] is the capture register, vld_pipe[STAGES] the output valid
    localparam int STAGES = 1;
    localparam int ESW    = MXHSB + 2;
    // one guard bit above the nominal width so even hs=all-ones cannot wrap before the clamp
    localparam int RAWW   = MXHSB + 4;
    localparam logic signed [RAWW-1:0] ES_MAX    = RAWW'(4*MXHS-1);
    localparam logic signed [RAWW-1:0] OFFS_ZERO = RAWW'(7);

    logic [STAGES:0]    vld_pipe;
    logic [MXHSB-1:0]   hs_q;
    logic [MXPIDB-1:0]  pid_q;
    logic [MXOFFSB-1:0] offs_q;
    logic [MXBNDB-1:0]  bend_q;

    logic signed [RAWW-1:0] es_raw;
    logic [ESW-1:0]         es_pos;
    logic                   clamp;

    always_comb begin
        es_raw = $signed({2'b00, hs_q, 2'b00}) + $signed({{(RAWW-MXOFFSB){1'b0}}, offs_q}) - OFFS_ZERO;
        es_pos = es_raw[ESW-1:0];
        clamp  = 1'b0;
        if (es_raw[RAWW-1]) begin
            es_pos = '0;
            clamp  = 1'b1;
        end else if (es_raw > ES_MAX) begin
            es_pos = ES_MAX[ESW-1:0];
            clamp  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe  <= '0;
            hs_q      <= '0;
            pid_q     <= '0;
            offs_q    <= '0;
            bend_q    <= '0;
            khs_out   <= '0;
            qs_out    <= 1'b0;
            es_out    <= 1'b0;
            slope_out <= '0;
            lr_out    <= 1'b0;
            pid_out   <= '0;
            clamp_out <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], vld};
            hs_q     <= hs;
            pid_q    <= pid;
            offs_q   <= offs;
            bend_q   <= bend;
            if (vld_pipe[0]) begin
                khs_out   <= es_pos[ESW-1:2];
                qs_out    <= es_pos[1];
                es_out    <= es_pos[0];
                slope_out <= bend_q[3:0];
                lr_out    <= bend_q[MXBNDB-1];
                pid_out   <= pid_q;
                clamp_out <= clamp;
            end else begin
                khs_out   <= '0;
                qs_out    <= 1'b0;
                es_out    <= 1'b0;
                slope_out <= '0;
                lr_out    <= 1'b0;
                pid_out   <= '0;
                clamp_out <= 1'b0;
            end
        end
    end

    assign vld_out = vld_pipe[STAGES];

`ifdef CCLUT_CLAMP_CNT_EN
    logic [MXCNTB-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset || cnt_clr)
            cnt_q <= '0;
        else if (vld_pipe[0] && clamp && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign clamp_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign clamp_cnt      = '0;
`endif
endmodule

module cclut_fine_position #(
    parameter int MXHSB   = 8,
    parameter int MXHS    = 224,
    parameter int MXPIDB  = 4,
    parameter int MXOFFSB = 4,
    parameter int MXBNDB  = 5,
    parameter int MXCNTB  = 16
) (
    input logic                clock,
    input logic                reset,
    cclut_fine_position_if.slave bus
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]              vld_i, vld_o, qs_o, es_o, lr_o, clamp_o;
    logic [NUM_LANES-1:0][MXHSB-1:0]   hs_i, khs_o;
    logic [NUM_LANES-1:0][MXPIDB-1:0]  pid_i, pid_o;
    logic [NUM_LANES-1:0][MXOFFSB-1:0] offs_i;
    logic [NUM_LANES-1:0][MXBNDB-1:0]  bend_i;
    logic [NUM_LANES-1:0][3:0]         slope_o;
    logic [NUM_LANES-1:0][MXCNTB-1:0]  cnt_o;

    assign vld_i  = {bus.vld1,  bus.vld0};
    assign hs_i   = {bus.hs1,   bus.hs0};
    assign pid_i  = {bus.pid1,  bus.pid0};
    assign offs_i = {bus.offs1, bus.offs0};
    assign bend_i = {bus.bend1, bus.bend0};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        cclut_fp_lane #(
            .MXHSB(MXHSB), .MXHS(MXHS), .MXPIDB(MXPIDB),
            .MXOFFSB(MXOFFSB), .MXBNDB(MXBNDB), .MXCNTB(MXCNTB)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .vld       (vld_i[l]),
            .hs        (hs_i[l]),
            .pid       (pid_i[l]),
            .offs      (offs_i[l]),
            .bend      (bend_i[l]),
            .cnt_clr   (bus.cnt_clr),
            .vld_out   (vld_o[l]),
            .khs_out   (khs_o[l]),
            .qs_out    (qs_o[l]),
            .es_out    (es_o[l]),
            .slope_out (slope_o[l]),
            .lr_out    (lr_o[l]),
            .pid_out   (pid_o[l]),
            .clamp_out (clamp_o[l]),
            .clamp_cnt (cnt_o[l])
        );
    end

    assign bus.vld_out0   = vld_o[0];
    assign bus.vld_out1   = vld_o[1];
    assign bus.khs_out0   = khs_o[0];
    assign bus.khs_out1   = khs_o[1];
    assign bus.qs_out0    = qs_o[0];
    assign bus.qs_out1    = qs_o[1];
    assign bus.es_out0    = es_o[0];
    assign bus.es_out1    = es_o[1];
    assign bus.slope_out0 = slope_o[0];
    assign bus.slope_out1 = slope_o[1];
    assign bus.lr_out0    = lr_o[0];
    assign bus.lr_out1    = lr_o[1];
    assign bus.pid_out0   = pid_o[0];
    assign bus.pid_out1   = pid_o[1];
    assign bus.clamp0     = clamp_o[0];
    assign bus.clamp1     = clamp_o[1];
    assign bus.clamp_cnt0 = cnt_o[0];
    assign bus.clamp_cnt1 = cnt_o[1];
endmodule

// File: tb/tb_cclut_fine_position.sv
// Scoreboard bench for cclut_fine_position: directed vectors push hand-computed results,
// a negedge monitor pops and compares them, including output cycle and clamp counters.
module tb_cclut_fine_position;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    cclut_fine_position_if #(.MXHSB(8), .MXPIDB(4), .MXOFFSB(4), .MXBNDB(5), .MXCNTB(16)) bus ();

    cclut_fine_position #(
        .MXHSB(8), .MXHS(224), .MXPIDB(4), .MXOFFSB(4), .MXBNDB(5), .MXCNTB(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit v;
        int hs, offs, bend, pid;
        int khs, qs, es, clamp;
    } vec_t;

    typedef struct {
        logic [7:0] khs;
        logic       qs, es;
        logic [3:0] slope;
        logic       lr;
        logic [3:0] pid;
        logic       clamp;
        int         due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] mcnt0 = '0;
    logic [15:0] mcnt1 = '0;
    logic        rst_seen = 1'b1;
    logic        clr_seen = 1'b0;

    always @(posedge clock) begin
        rst_seen <= reset;
        clr_seen <= bus.cnt_clr;
    end

    function automatic vec_t V(bit v, int hs, int offs, int bend, int pid,
                               int khs, int qs, int es, int clamp);
        vec_t r;
        r.v = v; r.hs = hs; r.offs = offs; r.bend = bend; r.pid = pid;
        r.khs = khs; r.qs = qs; r.es = es; r.clamp = clamp;
        return r;
    endfunction

    function automatic exp_t to_exp(vec_t a, int due);
        exp_t e;
        logic [4:0] b;
        b       = 5'(a.bend);
        e.khs   = 8'(a.khs);
        e.qs    = a.qs[0];
        e.es    = a.es[0];
        e.slope = b[3:0];
        e.lr    = b[4];
        e.pid   = 4'(a.pid);
        e.clamp = a.clamp[0];
        e.due   = due;
        return e;
    endfunction

    // one clock of stimulus; a reset cycle discards everything still in flight
    task automatic step(input bit rst, input bit clr, input vec_t a, input vec_t b);
        reset       = rst;
        bus.cnt_clr = clr;
        bus.vld0 = a.v; bus.hs0 = 8'(a.hs); bus.offs0 = 4'(a.offs); bus.bend0 = 5'(a.bend); bus.pid0 = 4'(a.pid);
        bus.vld1 = b.v; bus.hs1 = 8'(b.hs); bus.offs1 = 4'(b.offs); bus.bend1 = 5'(b.bend); bus.pid1 = 4'(b.pid);
        if (a.v && !rst) q0.push_back(to_exp(a, cyc + 2));
        if (b.v && !rst) q1.push_back(to_exp(b, cyc + 2));
        @(posedge clock);
        #1;
        if (rst) begin
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic check_lane(input int l, input logic v, input logic [7:0] khs, input logic qs,
                              input logic es, input logic [3:0] slope, input logic lr,
                              input logic [3:0] pid, input logic clamp, input logic [15:0] cnt);
        exp_t        e;
        logic [15:0] m;
        logic [15:0] want_cnt;
        bit          empty;
        m     = (l == 0) ? mcnt0 : mcnt1;
        empty = (l == 0) ? (q0.size() == 0) : (q1.size() == 0);
        checks++;
        if (v !== 1'b1) begin
            if (v !== 1'b0 || {khs, qs, es, slope, lr, pid, clamp} !== 20'h0) begin
                errors++;
                $display("FAIL idle_zero lane%0d cyc%0d: got vld=%b khs=%0d qs=%b es=%b slope=%0d lr=%b pid=%0d clamp=%b, want all 0",
                         l, cyc, v, khs, qs, es, slope, lr, pid, clamp);
            end
        end else if (empty) begin
            errors++;
            $display("FAIL unexpected_valid lane%0d cyc%0d: got vld=1 khs=%0d, want no output", l, cyc, khs);
        end else begin
            if (l == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if ({khs, qs, es, slope, lr, pid, clamp} !== {e.khs, e.qs, e.es, e.slope, e.lr, e.pid, e.clamp}
                || cyc != e.due) begin
                errors++;
                $display("FAIL result lane%0d: got cyc=%0d khs=%0d qs=%b es=%b slope=%0d lr=%b pid=%0d clamp=%b, want cyc=%0d khs=%0d qs=%b es=%b slope=%0d lr=%b pid=%0d clamp=%b",
                         l, cyc, khs, qs, es, slope, lr, pid, clamp,
                         e.due, e.khs, e.qs, e.es, e.slope, e.lr, e.pid, e.clamp);
            end
            if (e.clamp && m != 16'hFFFF) m = m + 16'd1;
        end
        if (rst_seen || clr_seen) m = '0;
`ifdef CCLUT_CLAMP_CNT_EN
        want_cnt = m;
`else
        want_cnt = '0;
`endif
        checks++;
        if (cnt !== want_cnt) begin
            errors++;
            $display("FAIL clamp_cnt lane%0d cyc%0d: got %h, want %h", l, cyc, cnt, want_cnt);
        end
        if (l == 0) mcnt0 = m;
        else        mcnt1 = m;
    endtask

    always @(negedge clock) begin
        check_lane(0, bus.vld_out0, bus.khs_out0, bus.qs_out0, bus.es_out0, bus.slope_out0,
                   bus.lr_out0, bus.pid_out0, bus.clamp0, bus.clamp_cnt0);
        check_lane(1, bus.vld_out1, bus.khs_out1, bus.qs_out1, bus.es_out1, bus.slope_out1,
                   bus.lr_out1, bus.pid_out1, bus.clamp1, bus.clamp_cnt1);
    end

    vec_t nop;

    initial begin
        nop = V(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.cnt_clr = 1'b0;
        bus.vld0 = 0; bus.hs0 = 0; bus.offs0 = 0; bus.bend0 = 0; bus.pid0 = 0;
        bus.vld1 = 0; bus.hs1 = 0; bus.offs1 = 0; bus.bend1 = 0; bus.pid1 = 0;
        repeat (2) @(posedge clock);
        #1;
        step(1, 0, nop, nop);

        // offset decoding, edge clamps on both sides, and exact-boundary non-clamps
        step(0, 0, V(1, 10,  7, 'h03, 1,  10, 0, 0, 0), nop);
        step(0, 0, V(1, 10,  0, 'h15, 2,   8, 0, 1, 0), nop);
        step(0, 0, V(1, 10,  1, 'h00, 3,   8, 1, 0, 0), nop);
        step(0, 0, V(1, 10, 11, 'h0F, 4,  11, 0, 0, 0), nop);
        step(0, 0, nop, V(1, 223, 15, 'h1A, 5, 223, 1, 1, 1));
        step(0, 0, V(1,  0,  0, 'h07, 6,   0, 0, 0, 1), V(1, 223, 10, 'h02, 7, 223, 1, 1, 0));
        step(0, 0, V(0, 50,  3, 'h1F, 9,   0, 0, 0, 0), V(1, 223, 11, 'h11, 8, 223, 1, 1, 1));
        step(0, 0, V(1,  1,  3, 'h04, 10,  0, 0, 0, 0), V(1,   1,  2, 'h08, 11,  0, 0, 0, 1));
        step(0, 0, V(1, 100, 9, 'h12, 12, 100, 1, 0, 0), V(1,  5,  4, 'h03, 13,  4, 0, 1, 0));
        repeat (3) step(0, 0, nop, nop);

        // five back-to-back candidates
        for (int i = 0; i < 5; i++)
            step(0, 0, V(1, 20 + i, 7, i, i, 20 + i, 0, 0, 0), nop);
        repeat (3) step(0, 0, nop, nop);

        // burst with reset on its third clock
        for (int i = 0; i < 5; i++)
            step(i == 2, 0, V(1, 40 + i, 7, 'h10 + i, i, 40 + i, 0, 0, 0),
                            V(1, 30 + i, 8, i, 15 - i, 30 + i, 0, 1, 0));
        repeat (4) step(0, 0, nop, nop);

`ifdef CCLUT_CLAMP_CNT_EN
        repeat (65536) step(0, 0, V(1, 0, 0, 0, 0, 0, 0, 0, 1), nop);
        repeat (3) step(0, 0, nop, nop);
        checks++;
        if (bus.clamp_cnt0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got %h, want ffff", bus.clamp_cnt0);
        end
        step(0, 0, V(1, 0, 0, 0, 0, 0, 0, 0, 1), nop);
        step(0, 1, nop, nop);
        repeat (3) step(0, 0, nop, nop);
        checks++;
        if (bus.clamp_cnt0 !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_clr_priority: got %h, want 0000", bus.clamp_cnt0);
        end
`endif

        repeat (4) step(0, 0, nop, nop);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d results never produced, want 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
